seg_scan_ctrl: RTL

- Time-multiplexes a 4-digit common-select 7-segment display through one shared seg7 decoder.
- Scans the digits in fixed order, inserts dead-time between digits, applies 16-level brightness PWM and optional leading-zero blanking.
- Accepts new 4-digit BCD values over a valid/ready handshake. New values are committed only at a frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller: fixed digit order, dead-time, 16-level PWM, leading-zero blanking.
// New BCD values are taken over valid/ready into a shadow register; load_ready stays low until the next frame commit.
module seg_scan_ctrl #(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [15:0] SCAN_DIV     = 16'd2500,
  parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_value,
  input  logic [3:0]  brightness,
  input  logic        lzb_en,
  output logic [3:0]  digit_code,
  output logic        blank,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int          SLOT_W    = $clog2(NUM_DIGITS);
  localparam logic [15:0] BLANK_W   = 16'(BLANK_CYCLES);
  localparam logic [15:0] STEP      = (SCAN_DIV - BLANK_W) / 16'd16;
  localparam logic [15:0] PH_LAST   = SCAN_DIV - 16'd1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [15:0]       ph;
  logic [SLOT_W-1:0] slot;
  logic [15:0]       disp;
  logic [15:0]       pend;
  logic              pend_v;
  logic [3:0]        bri_q;
  logic              lzb_q;

  logic        ph_wrap;
  logic        frame_end;
  logic [15:0] win_end;
  logic        lz;
  logic        lit;

  assign ph_wrap   = (ph == PH_LAST);
  assign frame_end = ph_wrap && (slot == SLOT_LAST);
  assign win_end   = BLANK_W + (16'(bri_q) + 16'd1) * STEP;

  // Digit i is suppressed when it and every more significant nibble are zero.
  always_comb begin
    lz = 1'b0;
    if (lzb_q && (slot != '0)) begin
      lz = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((i >= int'(slot)) && (disp[4*i +: 4] != 4'd0)) begin
          lz = 1'b0;
        end
      end
    end
  end

  assign lit = (ph >= BLANK_W) && (ph < win_end) && !lz;

  assign digit_sel  = lit ? (4'b0001 << slot) : 4'b0000;
  assign blank      = ~lit;
  assign digit_code = disp[{slot, 2'b00} +: 4];
  assign frame_done = frame_end;
  assign load_ready = ~pend_v;

  // lzb_en is registered so that no output has a combinational path from an input.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph     <= '0;
      slot   <= '0;
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      bri_q  <= brightness;
      lzb_q  <= lzb_en;
    end else begin
      lzb_q <= lzb_en;
      if (ph_wrap) begin
        ph    <= '0;
        slot  <= slot + SLOT_W'(1);
        bri_q <= brightness;
      end else begin
        ph <= ph + 16'd1;
      end
      // A transfer needs pend_v low, so it can never collide with a commit.
      if (frame_end && pend_v) begin
        disp   <= pend;
        pend_v <= 1'b0;
      end else if (load_valid && !pend_v) begin
        pend   <= load_value;
        pend_v <= 1'b1;
      end
    end
  end

endmodule
